// File: rtl/approx_err_monitor_if.sv
// Sample stream between the approximate multiplier under test and the error monitor.
// The master drives the operands, the approximate product and in_valid.
// The slave (the monitor) returns in_ready.
//   in_valid : a sample is present on in_a / in_b / in_r
//   in_ready : the monitor accepts a sample this cycle
//   in_a     : 8-bit multiplicand given to the approximate multiplier
//   in_b     : 8-bit multiplier given to the approximate multiplier
//   in_r     : 16-bit approximate product the multiplier returned for in_a, in_b
interface approx_err_monitor_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [15:0] in_r;

    modport master (output in_valid, in_a, in_b, in_r, input in_ready);
    modport slave  (input in_valid, in_a, in_b, in_r, output in_ready);
endinterface

// File: rtl/approx_err_monitor.sv
// Error-statistics monitor for an 8x8 approximate multiplier.
// A run starts from idle on start and latches num_samples as N. The monitor then
// accepts N samples. For each sample it computes the exact product in_a*in_b and
// compares it with the approximate product in_r. It keeps four statistics:
//   - the saturating sum of |exact - in_r|
//   - the maximum of |exact - in_r|
//   - the count of samples with a nonzero error
//   - the count of samples where in_r exceeds the exact product
// After the last sample the pipeline drains for two cycles. done then pulses for
// one cycle and the statistics hold until the next accepted start.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : begin a run (only honoured in idle)
//   num_samples   : samples per run, latched on the accepted start
//   smp           : sample stream (in_valid/in_ready/in_a/in_b/in_r)
//   busy, done    : run in progress / one-cycle completion pulse
//   err_sum       : saturating sum of absolute errors
//   err_max       : maximum absolute error
//   err_cnt       : count of samples with a nonzero error
//   over_cnt      : count of samples where in_r is above the exact product
module approx_err_monitor #(
    parameter int unsigned CNT_W = 17,
    parameter int unsigned ACC_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    num_samples,
    approx_err_monitor_if.slave smp,
    output logic                busy,
    output logic                done,
    output logic [ACC_W-1:0]    err_sum,
    output logic [15:0]         err_max,
    output logic [CNT_W-1:0]    err_cnt,
    output logic [CNT_W-1:0]    over_cnt
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] n_q, acc_cnt_q;
    logic             drain_q;
    logic             in_ready, accept, start_acc;

    logic             s1_vld_q, s2_vld_q, s2_over_q;
    logic [15:0]      s1_exact_q, s1_r_q, s2_err_q;
    logic [15:0]      exact_c, err_c;
    logic             over_c;

    logic [ACC_W-1:0] err_sum_q;
    logic [15:0]      err_max_q;
    logic [CNT_W-1:0] err_cnt_q, over_cnt_q;
    logic [ACC_W:0]   sum_ext;

    assign start_acc    = (state_q == StIdle) && start;
    assign accept       = smp.in_valid && in_ready;
    assign smp.in_ready = in_ready;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (acc_cnt_q == n_q) state_d = StDrain;
            StDrain: if (drain_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready = (state_q == StRun) && (acc_cnt_q < n_q);
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
    end

    // Run bookkeeping. drain_q marks the second drain cycle. That gives the last
    // sample time to pass stages 2 and 3 before done is raised.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_q       <= '0;
            acc_cnt_q <= '0;
            drain_q   <= 1'b0;
        end else begin
            if (start_acc) begin
                n_q       <= num_samples;
                acc_cnt_q <= '0;
            end else if (accept) begin
                acc_cnt_q <= acc_cnt_q + CNT_W'(1);
            end
            drain_q <= (state_q == StDrain) ? ~drain_q : 1'b0;
        end
    end

    // Stage 1 and stage 2 combinational terms
    assign exact_c = {8'd0, smp.in_a} * {8'd0, smp.in_b};
    assign over_c  = s1_r_q > s1_exact_q;
    assign err_c   = over_c ? (s1_r_q - s1_exact_q) : (s1_exact_q - s1_r_q);

    // Stage 1: exact product; stage 2: absolute error and the over flag
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_exact_q <= '0;
            s1_r_q     <= '0;
            s2_vld_q   <= 1'b0;
            s2_err_q   <= '0;
            s2_over_q  <= 1'b0;
        end else begin
            s1_vld_q <= accept;
            if (accept) begin
                s1_exact_q <= exact_c;
                s1_r_q     <= smp.in_r;
            end
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_err_q  <= err_c;
                s2_over_q <= over_c;
            end
        end
    end

    // Stage 3: accumulators. The extra carry bit detects overflow, and on overflow
    // the sum is pinned at all-ones.
    assign sum_ext = {1'b0, err_sum_q} + {{(ACC_W - 15){1'b0}}, s2_err_q};

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            err_sum_q  <= '0;
            err_max_q  <= '0;
            err_cnt_q  <= '0;
            over_cnt_q <= '0;
        end else if (s2_vld_q) begin
            err_sum_q <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
            if (s2_err_q > err_max_q) err_max_q <= s2_err_q;
            if (s2_err_q != 16'd0) err_cnt_q <= err_cnt_q + CNT_W'(1);
            if (s2_over_q) over_cnt_q <= over_cnt_q + CNT_W'(1);
        end
    end

    assign err_sum  = err_sum_q;
    assign err_max  = err_max_q;
    assign err_cnt  = err_cnt_q;
    assign over_cnt = over_cnt_q;

endmodule
